md_pad_responder: RTL and testbench



---
 rtl/md_pad_responder_if.sv | 12 +
 rtl/md_pad_responder.sv | 174 +++++++++++++++++
 tb/tb_md_pad_responder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/md_pad_responder_if.sv
// Mega Drive DB9 pad bus: host-driven select (TH) and the six
// device-driven, active-low data pins.
interface md_pad_responder_if;
  logic       sel_in;
  logic [5:0] joy_out;

  // Host side: drives select, samples the data pins.
  modport master (output sel_in, input joy_out);

  // Pad side: receives select, drives the data pins.
  modport slave (input sel_in, output joy_out);
endinterface

// File: rtl/md_pad_responder.sv
// md_pad_responder: device-side Mega Drive pad emulation.
// Presents 12 active-high core buttons as a Sega pad to an external host
// that toggles select (TH) asynchronously and samples D0..D3/TL/TR.
//
// Build option MD_PAD_SIX_BTN_EN:
//   defined   - 8-phase 6-button protocol with select-idle timeout
//   undefined - 3-button pad; phase[0] follows select, timeout tied low
//
// phase | meaning
// ------+-----------------------------------------------
//   0   | sel high : U D L R B C
//   1   | sel low  : U D 0 0 A Start
//   2   | sel high : U D L R B C
//   3   | sel low  : U D 0 0 A Start
//   4   | sel high : U D L R B C
//   5   | sel low  : 6-button ID (D0..D3 = 0), A Start
//   6   | sel high : Z Y X Mode B C
//   7   | sel low  : D0..D3 = 1, A Start
module md_pad_responder #(
  parameter int CLK_HZ     = 48000000,
  parameter int TIMEOUT_US = 1500
) (
  input  logic              clk,
  input  logic              reset_n,
  md_pad_responder_if.slave pad,
  input  logic [11:0]       btn,
  output logic [2:0]        phase,
  output logic              timeout
);

  localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;

  logic        sync1;
  logic        sel_s;
  logic [11:0] btn_q;
  logic [5:0]  joy_q;
  logic [5:0]  joy_nxt;

  // Two-flop synchronizer for the host select; idles high like the pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sel_s <= 1'b1;
    end else begin
      sync1 <= pad.sel_in;
      sel_s <= sync1;
    end
  end

  // Single register stage on the button inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn;
    end
  end

`ifdef MD_PAD_SIX_BTN_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_PRE = CW'(TIMEOUT_CYC - 1);

  logic          sel_q;
  logic          edge_det;
  logic [2:0]    phase_q;
  logic [2:0]    phase_nxt;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic          timeout_q;
  logic          timeout_nxt;

  assign edge_det = sel_s ^ sel_q;

  // State register: phase, idle counter, timeout pulse, previous select.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q     <= 1'b1;
      phase_q   <= 3'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      sel_q     <= sel_s;
      phase_q   <= phase_nxt;
      cnt_q     <= cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  // Next state: a select edge always advances the phase and restarts the
  // idle count, so it wins over a timeout landing in the same cycle. The
  // timeout fires once as the counter saturates and snaps the phase back
  // to the start that matches the present select level.
  always_comb begin
    phase_nxt   = phase_q;
    cnt_nxt     = cnt_q;
    timeout_nxt = 1'b0;
    if (edge_det) begin
      phase_nxt = phase_q + 3'd1;
      cnt_nxt   = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_nxt = cnt_q + 1'b1;
      if (cnt_q == CNT_PRE) begin
        phase_nxt   = sel_s ? 3'd0 : 3'd1;
        timeout_nxt = 1'b1;
      end
    end
  end

  assign phase   = phase_q;
  assign timeout = timeout_q;

  // Output decode: pin pattern for the current phase (pressed drives 0).
  always_comb begin
    joy_nxt = 6'h3F;
    case (phase_q)
      3'd1, 3'd3: joy_nxt = {~btn_q[7], ~btn_q[6], 2'b00, ~btn_q[2], ~btn_q[3]};
      3'd5:       joy_nxt = {~btn_q[7], ~btn_q[6], 4'b0000};
      3'd6:       joy_nxt = {~btn_q[5], ~btn_q[4], ~btn_q[8], ~btn_q[9],
                             ~btn_q[10], ~btn_q[11]};
      3'd7:       joy_nxt = {~btn_q[7], ~btn_q[6], 4'b1111};
      default:    joy_nxt = {~btn_q[5], ~btn_q[4], ~btn_q[0], ~btn_q[1],
                             ~btn_q[2], ~btn_q[3]};
    endcase
  end
`else
  logic ph0_q;
  logic ph0_nxt;
  logic unused_cfg;

  // Extended buttons and the timeout length have no role on a 3-button pad.
  assign unused_cfg = ^{btn_q[11:8], TIMEOUT_CYC[0]};

  // State register: the only state is which half of the read is selected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph0_q <= 1'b0;
    end else begin
      ph0_q <= ph0_nxt;
    end
  end

  // Next state: odd phase while select is low.
  always_comb begin
    ph0_nxt = ~sel_s;
  end

  assign phase   = {2'b00, ph0_q};
  assign timeout = 1'b0;

  // Output decode: phase 0/1 rows of the pad map (pressed drives 0).
  always_comb begin
    joy_nxt = 6'h3F;
    if (ph0_q) begin
      joy_nxt = {~btn_q[7], ~btn_q[6], 2'b00, ~btn_q[2], ~btn_q[3]};
    end else begin
      joy_nxt = {~btn_q[5], ~btn_q[4], ~btn_q[0], ~btn_q[1],
                 ~btn_q[2], ~btn_q[3]};
    end
  end
`endif

  // Register the decoded pins so the pad never glitches toward the host.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      joy_q <= 6'h3F;
    end else begin
      joy_q <= joy_nxt;
    end
  end

  assign pad.joy_out = joy_q;

endmodule

// File: tb/tb_md_pad_responder.sv
// Directed testbench for md_pad_responder (3-button default build, plus
// 6-button phases and idle timeout when MD_PAD_SIX_BTN_EN is defined).
module tb_md_pad_responder;
  localparam int TUS = 20;
  localparam int T   = 48 * TUS;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] btn;
  logic [2:0]  phase;
  logic        timeout;
  logic [2:0]  exp_phase;
  int          errors = 0;
  int          checks = 0;
  int          tcount = 0;
  int          tbase;

  md_pad_responder_if pad ();

  md_pad_responder #(.CLK_HZ(48000000), .TIMEOUT_US(TUS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pad     (pad.slave),
    .btn     (btn),
    .phase   (phase),
    .timeout (timeout)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (timeout === 1'b1) tcount++;
  end

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic v);
    @(negedge clk);
    pad.sel_in = v;
`ifdef MD_PAD_SIX_BTN_EN
    exp_phase = exp_phase + 3'd1;
`else
    exp_phase = {2'b00, ~v};
`endif
  endtask

  task automatic toggle(input logic v);
    set_sel(v);
    clks(4);
  endtask

  task automatic set_btn(input logic [11:0] b);
    @(negedge clk);
    btn = b;
    clks(2);
  endtask

  initial begin
    pad.sel_in = 1'b1;
    btn        = 12'hFFF;
    reset_n    = 1'b0;
    exp_phase  = 3'd0;
    #25;
    check("rst_joy", 12'(pad.joy_out), 12'h03F);
    check("rst_phase", 12'(phase), 12'h000);
    check("rst_timeout", 12'(timeout), 12'h000);

    @(negedge clk);
    reset_n = 1'b1;
    clks(3);
    check("all_pressed_ph0", 12'(pad.joy_out), 12'h000);

    @(negedge clk);
    btn = 12'h0C1;
    clks(1);
    check("btn_lat_1clk", 12'(pad.joy_out), 12'h000);
    clks(1);
    check("btn_lat_2clk", 12'(pad.joy_out), 12'h037);

    set_sel(1'b0);
    clks(2);
    check("sync_depth", 12'(phase), 12'h000);
    clks(1);
    check("fall_phase", 12'(phase), 12'(exp_phase));
    check("fall_joy_hold", 12'(pad.joy_out), 12'h037);
    clks(1);
    check("fall_joy", 12'(pad.joy_out), 12'h003);

    set_btn(12'hF00);
    check("odd_ext_ignored", 12'(pad.joy_out), 12'h033);
    toggle(1'b1);
    check("rise_phase", 12'(phase), 12'(exp_phase));
    check("even_ext_ignored", 12'(pad.joy_out), 12'h03F);
    set_btn(12'h03F);
    check("even_dpad_bc", 12'(pad.joy_out), 12'h000);
    toggle(1'b0);
    check("fall2_phase", 12'(phase), 12'(exp_phase));
    check("odd_dpad", 12'(pad.joy_out), 12'h030);
    set_btn(12'h015);
    check("odd_mix", 12'(pad.joy_out), 12'h031);
    toggle(1'b1);
    check("rise2_phase", 12'(phase), 12'(exp_phase));
    check("even_mix", 12'(pad.joy_out), 12'h025);

`ifdef MD_PAD_SIX_BTN_EN
    clks(T - 2);
    check("to1_early", 12'(timeout), 12'h000);
    clks(1);
    check("to1_pulse", 12'(timeout), 12'h001);
    check("to1_phase", 12'(phase), 12'h000);
    exp_phase = 3'd0;
    clks(1);
    check("to1_single", 12'(timeout), 12'h000);
    clks(1000);
    check("to1_no_repeat", 12'(tcount), 12'h001);

    set_btn(12'h000);
    toggle(1'b0);
    toggle(1'b1);
    toggle(1'b0);
    toggle(1'b1);
    toggle(1'b0);
    check("to2_start_phase", 12'(phase), 12'h005);
    clks(T - 2);
    check("to2_early", 12'(timeout), 12'h000);
    clks(1);
    check("to2_pulse", 12'(timeout), 12'h001);
    check("to2_phase", 12'(phase), 12'h001);
    exp_phase = 3'd1;

    toggle(1'b1);
    toggle(1'b0);
    toggle(1'b1);
    toggle(1'b0);
    check("id_phase", 12'(phase), 12'h005);
    check("id_joy", 12'(pad.joy_out), 12'h030);
    toggle(1'b1);
    check("ph6_phase", 12'(phase), 12'h006);
    check("ph6_joy", 12'(pad.joy_out), 12'h03F);
    toggle(1'b0);
    check("ph7_phase", 12'(phase), 12'h007);
    check("ph7_joy", 12'(pad.joy_out), 12'h03F);
    toggle(1'b1);
    check("wrap_phase", 12'(phase), 12'h000);
    check("wrap_joy", 12'(pad.joy_out), 12'h03F);

    set_btn(12'hA00);
    check("ext_hidden_ph0", 12'(pad.joy_out), 12'h03F);
    toggle(1'b0);
    toggle(1'b1);
    toggle(1'b0);
    toggle(1'b1);
    toggle(1'b0);
    toggle(1'b1);
    check("ext_phase", 12'(phase), 12'h006);
    check("ext_joy", 12'(pad.joy_out), 12'h03A);

    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_phase", 12'(phase), 12'h000);
    check("async_rst_joy", 12'(pad.joy_out), 12'h03F);
    @(negedge clk);
    reset_n   = 1'b1;
    exp_phase = 3'd0;

    tbase = tcount;
    set_sel(1'b0);
    clks(4);
    check("coll_first", 12'(phase), 12'h001);
    repeat (T - 4) @(negedge clk);
    set_sel(1'b1);
    clks(4);
    check("coll_phase", 12'(phase), 12'h002);
    check("coll_no_pulse", 12'(tcount - tbase), 12'h000);
    check("total_pulses", 12'(tcount), 12'h002);
`else
    clks(1100);
    check("no_timeout", 12'(tcount), 12'h000);
    check("idle_phase", 12'(phase), 12'(exp_phase));
    toggle(1'b0);
    check("3b_fall_phase", 12'(phase), 12'h001);
    check("3b_fall_joy", 12'(pad.joy_out), 12'h031);
    toggle(1'b1);
    check("3b_rise_phase", 12'(phase), 12'h000);
    check("3b_rise_joy", 12'(pad.joy_out), 12'h025);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
